// File: rtl/regfile_access_ctrl_if.sv
// Register-file access bus: core/host write requests, read port 1, RF write port and dump stream.
// The slave modport is the controller's view; master is the surrounding core/host/register-file side.
interface regfile_access_ctrl_if;
   logic        core_wvalid;
   logic [4:0]  core_waddr;
   logic [31:0] core_wdata;
   logic        core_wready;
   logic        host_wvalid;
   logic [4:0]  host_waddr;
   logic [31:0] host_wdata;
   logic        host_wready;
   logic [4:0]  core_ra1;
   logic        core_stall;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;
   logic [4:0]  rf_a1;
   logic [31:0] rf_rd1;
   logic        dump_start;
   logic        dump_busy;
   logic        dump_valid;
   logic [4:0]  dump_idx;
   logic [31:0] dump_data;
   logic        dump_ready;

   modport slave (
      input  core_wvalid, core_waddr, core_wdata, host_wvalid, host_waddr, host_wdata,
      input  core_ra1, rf_rd1, dump_start, dump_ready,
      output core_wready, host_wready, core_stall, rf_we, rf_a3, rf_wd, rf_a1,
      output dump_busy, dump_valid, dump_idx, dump_data
   );

   modport master (
      output core_wvalid, core_waddr, core_wdata, host_wvalid, host_waddr, host_wdata,
      output core_ra1, rf_rd1, dump_start, dump_ready,
      input  core_wready, host_wready, core_stall, rf_we, rf_a3, rf_wd, rf_a1,
      input  dump_busy, dump_valid, dump_idx, dump_data
   );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Round-robin arbiter for the RF write port (combinational, same-cycle commit) plus a x0..x31 dump sequencer
// on read port 1: one beat per LOAD/HOLD pair, beat held while dump_ready is low, writes blocked during a dump.
module regfile_access_ctrl (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   regfile_access_ctrl_if.slave        io_bus
);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   localparam logic GNT_CORE = 1'b0;
   localparam logic GNT_HOST = 1'b1;

   state_t      r_state;
   logic [4:0]  r_idx;
   logic        r_last_grant;
   logic        r_dump_valid;
   logic        r_dump_busy;
   logic [4:0]  r_dump_idx;
   logic [31:0] r_dump_data;

   logic        w_idle;
   logic        w_core_hs;
   logic        w_host_hs;
   logic [4:0]  w_a3;

   assign w_idle = (r_state == IDLE);

   // Both readies already include valid, so ready doubles as the handshake strobe.
   assign w_core_hs = i_rst_n && w_idle && io_bus.core_wvalid &&
                      (!io_bus.host_wvalid || (r_last_grant == GNT_HOST));
   assign w_host_hs = i_rst_n && w_idle && io_bus.host_wvalid &&
                      (!io_bus.core_wvalid || (r_last_grant == GNT_CORE));

   assign w_a3 = w_host_hs ? io_bus.host_waddr : io_bus.core_waddr;

   assign io_bus.core_wready = w_core_hs;
   assign io_bus.host_wready = w_host_hs;
   assign io_bus.rf_a3       = w_a3;
   assign io_bus.rf_wd       = w_host_hs ? io_bus.host_wdata : io_bus.core_wdata;
   assign io_bus.rf_we       = (w_core_hs || w_host_hs) && (w_a3 != 5'd0);
   assign io_bus.rf_a1       = w_idle ? io_bus.core_ra1 : r_idx;
   assign io_bus.core_stall  = !w_idle;
   assign io_bus.dump_valid  = r_dump_valid;
   assign io_bus.dump_busy   = r_dump_busy;
   assign io_bus.dump_idx    = r_dump_idx;
   assign io_bus.dump_data   = r_dump_data;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_idx        <= 5'd0;
         r_last_grant <= GNT_HOST;
         r_dump_valid <= 1'b0;
         r_dump_busy  <= 1'b0;
         r_dump_idx   <= 5'd0;
         r_dump_data  <= 32'd0;
      end else begin
         if (w_core_hs) begin
            r_last_grant <= GNT_CORE;
         end else if (w_host_hs) begin
            r_last_grant <= GNT_HOST;
         end
         case (r_state)
            IDLE: begin
               if (io_bus.dump_start) begin
                  r_state     <= LOAD;
                  r_idx       <= 5'd0;
                  r_dump_busy <= 1'b1;
               end
            end
            LOAD: begin
               r_dump_data  <= io_bus.rf_rd1;
               r_dump_idx   <= r_idx;
               r_dump_valid <= 1'b1;
               r_state      <= HOLD;
            end
            HOLD: begin
               if (io_bus.dump_ready) begin
                  r_dump_valid <= 1'b0;
                  if (r_idx == 5'd31) begin
                     r_state     <= IDLE;
                     r_dump_busy <= 1'b0;
                  end else begin
                     r_idx   <= r_idx + 5'd1;
                     r_state <= LOAD;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle compared against a
// behavioural model (register array snapshot + expected beat sequence) and an RF memory model.
module tb_regfile_access_ctrl;

   logic clk;
   logic rst_n;

   regfile_access_ctrl_if bus ();

   regfile_access_ctrl dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file behind the controller.
   logic [31:0] rf_mem [32];
   always @(posedge clk) begin
      if (bus.rf_we === 1'b1) rf_mem[bus.rf_a3] <= bus.rf_wd;
   end
   assign bus.rf_rd1 = rf_mem[bus.rf_a1];

   int n_total;
   int n_pass;

   // Reference model state.
   logic [31:0] m_regs [32];
   logic [31:0] m_snap [32];
   bit          m_last_host;
   bit          m_dump;
   bit          m_shown;
   int          m_next;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Compare one cycle against the model, then advance the model and the clock.
   task automatic step();
      bit          e_c, e_h, e_we;
      logic [4:0]  e_a;
      logic [31:0] e_d;
      #1;
      e_c  = bus.core_wvalid && (!bus.host_wvalid || m_last_host);
      e_h  = bus.host_wvalid && (!bus.core_wvalid || !m_last_host);
      e_a  = e_h ? bus.host_waddr : bus.core_waddr;
      e_d  = e_h ? bus.host_wdata : bus.core_wdata;
      e_we = (e_c || e_h) && (e_a != 5'd0);
      if (!rst_n) begin
         chk("rst_core_wready", {31'd0, bus.core_wready}, 32'd0);
         chk("rst_host_wready", {31'd0, bus.host_wready}, 32'd0);
         chk("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
         m_dump      = 1'b0;
         m_shown     = 1'b0;
         m_last_host = 1'b1;
      end else begin
         chk("dump_busy", {31'd0, bus.dump_busy}, {31'd0, m_dump});
         chk("dump_valid", {31'd0, bus.dump_valid}, {31'd0, m_dump && m_shown});
         if (m_dump) begin
            chk("blk_core_wready", {31'd0, bus.core_wready}, 32'd0);
            chk("blk_host_wready", {31'd0, bus.host_wready}, 32'd0);
            chk("blk_rf_we", {31'd0, bus.rf_we}, 32'd0);
            chk("blk_stall", {31'd0, bus.core_stall}, 32'd1);
            chk("blk_rf_a1", {27'd0, bus.rf_a1}, m_next);
            if (m_shown) begin
               chk("beat_idx", {27'd0, bus.dump_idx}, m_next);
               chk("beat_data", bus.dump_data, m_snap[m_next]);
               if (bus.dump_ready) begin
                  m_shown = 1'b0;
                  m_next  = m_next + 1;
                  if (m_next == 32) m_dump = 1'b0;
               end
            end else begin
               m_shown = 1'b1;
            end
         end else begin
            chk("core_wready", {31'd0, bus.core_wready}, {31'd0, e_c});
            chk("host_wready", {31'd0, bus.host_wready}, {31'd0, e_h});
            chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e_we});
            chk("rf_a3", {27'd0, bus.rf_a3}, {27'd0, e_a});
            chk("rf_wd", bus.rf_wd, e_d);
            chk("stall", {31'd0, bus.core_stall}, 32'd0);
            chk("rf_a1", {27'd0, bus.rf_a1}, {27'd0, bus.core_ra1});
            if (e_c || e_h) m_last_host = e_h;
            if (e_we) m_regs[e_a] = e_d;
            if (bus.dump_start) begin
               m_dump  = 1'b1;
               m_shown = 1'b0;
               m_next  = 0;
               for (int i = 0; i < 32; i++) m_snap[i] = m_regs[i];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.core_wvalid = 1'b0;
      bus.host_wvalid = 1'b0;
      bus.dump_start  = 1'b0;
      bus.dump_ready  = 1'b1;
   endtask

   initial begin
      logic [31:0] cap [32];
      int          first_vld;
      int          beats;
      int          hold_cnt;
      int          last_idx;
      logic [31:0] bp_data;

      n_total = 0;
      n_pass  = 0;
      for (int i = 0; i < 32; i++) begin
         rf_mem[i] = 32'd0;
         m_regs[i] = 32'd0;
         m_snap[i] = 32'd0;
         cap[i]    = 32'hFFFF_FFFF;
      end
      m_last_host = 1'b1;
      m_dump      = 1'b0;
      m_shown     = 1'b0;
      m_next      = 0;

      rst_n          = 1'b0;
      bus.core_wvalid = 1'b1;
      bus.core_waddr  = 5'd5;
      bus.core_wdata  = 32'h0000_0555;
      bus.host_wvalid = 1'b1;
      bus.host_waddr  = 5'd6;
      bus.host_wdata  = 32'h0000_0666;
      bus.core_ra1    = 5'd1;
      bus.dump_start  = 1'b0;
      bus.dump_ready  = 1'b1;
      #1;

      // Reset with both requesters valid.
      for (int i = 0; i < 3; i++) step();
      chk("reset_dump_valid", {31'd0, bus.dump_valid}, 32'd0);
      chk("reset_dump_busy", {31'd0, bus.dump_busy}, 32'd0);
      chk("reset_dump_idx", {27'd0, bus.dump_idx}, 32'd0);
      chk("reset_dump_data", bus.dump_data, 32'd0);

      // Round-robin from release: core, host, core, host.
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_core_grant", {31'd0, bus.core_wready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_rf_a3", {27'd0, bus.rf_a3}, (i % 2 == 0) ? 32'd5 : 32'd6);
         chk("rr_rf_we", {31'd0, bus.rf_we}, 32'd1);
         step();
      end

      // Host write to x0: handshake but no RF write.
      bus.core_wvalid = 1'b0;
      bus.host_waddr  = 5'd0;
      bus.host_wdata  = 32'hDEAD_BEEF;
      #1;
      chk("x0_host_wready", {31'd0, bus.host_wready}, 32'd1);
      chk("x0_rf_we", {31'd0, bus.rf_we}, 32'd0);
      step();

      // Random write traffic, then the known preloads.
      for (int i = 0; i < 40; i++) begin
         bus.core_wvalid = 1'($urandom_range(0, 1));
         bus.host_wvalid = 1'($urandom_range(0, 1));
         bus.core_waddr  = 5'($urandom);
         bus.host_waddr  = 5'($urandom);
         bus.core_wdata  = $urandom;
         bus.host_wdata  = $urandom;
         bus.core_ra1    = 5'($urandom);
         step();
      end
      bus.core_wvalid = 1'b0;
      bus.host_wvalid = 1'b1;
      bus.host_waddr  = 5'd8;
      bus.host_wdata  = 32'h0000_0011;
      step();
      bus.host_waddr  = 5'd31;
      bus.host_wdata  = 32'hA5A5_A5A5;
      step();

      // Full dump with dump_ready held high.
      idle_inputs();
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      first_vld = -1;
      beats     = 0;
      for (int k = 1; k < 100; k++) begin
         if (!bus.dump_busy) break;
         if (bus.dump_valid) begin
            if (first_vld < 0) first_vld = k;
            cap[bus.dump_idx] = bus.dump_data;
            beats = beats + 1;
         end
         step();
      end
      chk("dump_first_latency", first_vld, 32'd2);
      chk("dump_beats", beats, 32'd32);
      chk("dump_busy_end", {31'd0, bus.dump_busy}, 32'd0);
      chk("dump_x0", cap[0], 32'd0);
      chk("dump_x8", cap[8], 32'h0000_0011);
      chk("dump_x31", cap[31], 32'hA5A5_A5A5);

      // Backpressure at idx 3 with a pending core write.
      bus.core_wvalid = 1'b1;
      bus.core_waddr  = 5'd7;
      bus.core_wdata  = 32'h7777_0007;
      bus.dump_start  = 1'b1;
      step();
      bus.dump_start  = 1'b0;
      bus.core_wdata  = 32'h7777_0008;
      hold_cnt = 0;
      bp_data  = 32'd0;
      for (int k = 0; k < 200; k++) begin
         if (!bus.dump_busy) break;
         bus.dump_ready = 1'b1;
         if (bus.dump_valid && bus.dump_idx == 5'd3 && hold_cnt < 5) begin
            bus.dump_ready = 1'b0;
            if (hold_cnt == 0) bp_data = bus.dump_data;
            hold_cnt = hold_cnt + 1;
            chk("bp_valid", {31'd0, bus.dump_valid}, 32'd1);
            chk("bp_idx", {27'd0, bus.dump_idx}, 32'd3);
            chk("bp_data", bus.dump_data, m_snap[3]);
            chk("bp_core_wready", {31'd0, bus.core_wready}, 32'd0);
            chk("bp_stall", {31'd0, bus.core_stall}, 32'd1);
         end
         step();
      end
      chk("bp_hold_cycles", hold_cnt, 32'd5);
      chk("bp_done", {31'd0, bus.dump_busy}, 32'd0);
      #1;
      chk("bp_core_accept", {31'd0, bus.core_wready}, 32'd1);
      step();
      bus.core_wvalid = 1'b0;

      // Abort at idx 10, restart, and ignore a mid-dump start pulse.
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (bus.dump_valid && bus.dump_idx == 5'd10) break;
         step();
      end
      chk("abort_reach_idx10", {27'd0, bus.dump_idx}, 32'd10);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_valid", {31'd0, bus.dump_valid}, 32'd0);
      chk("abort_busy", {31'd0, bus.dump_busy}, 32'd0);
      chk("abort_stall", {31'd0, bus.core_stall}, 32'd0);
      step();
      chk("abort_no_beat", {31'd0, bus.dump_valid}, 32'd0);
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (bus.dump_valid) break;
         step();
      end
      chk("restart_valid", {31'd0, bus.dump_valid}, 32'd1);
      chk("restart_idx", {27'd0, bus.dump_idx}, 32'd0);
      last_idx = -1;
      for (int k = 0; k < 100; k++) begin
         if (!bus.dump_busy) break;
         bus.dump_start = (bus.dump_valid && bus.dump_idx == 5'd5) ? 1'b1 : 1'b0;
         if (bus.dump_valid) last_idx = bus.dump_idx;
         step();
      end
      bus.dump_start = 1'b0;
      chk("ignore_last_idx", last_idx, 32'd31);
      chk("ignore_busy_end", {31'd0, bus.dump_busy}, 32'd0);

      // Random mixed traffic: writes, dump starts and backpressure.
      for (int i = 0; i < 400; i++) begin
         bus.core_wvalid = 1'($urandom_range(0, 1));
         bus.host_wvalid = 1'($urandom_range(0, 1));
         bus.core_waddr  = 5'($urandom);
         bus.host_waddr  = 5'($urandom);
         bus.core_wdata  = $urandom;
         bus.host_wdata  = $urandom;
         bus.core_ra1    = 5'($urandom);
         bus.dump_start  = ($urandom_range(0, 15) == 0);
         bus.dump_ready  = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Controller for the 32x32 register file's single write port and its first read port in the multicycle RISC-V core. It shares the write port between the core writeback stage and an external host/loader using valid/ready handshakes with round-robin arbitration, and suppresses writes to x0. It also runs a dump sequencer that walks x0..x31 through read port 1 and streams the contents to the host. Register writes are blocked during a dump so the snapshot is coherent.

## Interface
- No parameters; widths are fixed (5-bit register index, 32-bit data).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- core_wvalid / core_waddr / core_wdata  in  1/5/32  core writeback request.
- core_wready  out  1  core write accepted this cycle.
- host_wvalid / host_waddr / host_wdata  in  1/5/32  host/loader write request.
- host_wready  out  1  host write accepted this cycle.
- core_ra1  in  5  core read address for read port 1.
- core_stall  out  1  high while a dump owns read port 1.
- rf_we / rf_a3 / rf_wd  out  1/5/32  drive the register file write port.
- rf_a1  out  5  drives register file read address 1.
- rf_rd1  in  32  register file read data 1; combinational read.
- dump_start  in  1  one-cycle pulse that requests a full register dump.
- dump_busy  out  1  high from the cycle after dump_start is accepted until the last beat completes.
- dump_valid / dump_idx / dump_data  out  1/5/32  dump beat: register number and its value.
- dump_ready  in  1  host accepts the dump beat.

## Operation
- **FSM states:** IDLE, LOAD, HOLD.
- **Reset** (rst low at a clock edge) → IDLE. The following are registered outputs and reset to 0: dump_valid, dump_busy, dump_idx, dump_data. last_grant resets to HOST, so the core wins the first conflict.
- **During reset:** while rst is low, core_wready, host_wready and rf_we are forced to 0 combinationally.
- **IDLE, write arbitration:**
  - Only one requester valid → that requester gets ready.
  - Both valid → the requester not equal to last_grant gets ready.
  - A handshake is valid && ready in the same cycle.
  - On a handshake: rf_a3 and rf_wd are taken from the winner, and last_grant is updated to the winner.
  - rf_we = handshake && addr != 0. A write to x0 still completes the handshake and updates last_grant, but leaves rf_we low.
  - With no handshake, rf_a3 and rf_wd follow the core inputs and rf_we is 0.
- **Read port 1 outside a dump:** rf_a1 = core_ra1 and core_stall = 0.
- **Starting a dump:** dump_start in IDLE → LOAD next cycle, with idx = 0. A write handshake in the same cycle as dump_start still completes.
- **LOAD:**
  - rf_a1 = idx.
  - At the clock edge: dump_data <= rf_rd1, dump_idx <= idx, dump_valid <= 1, then go to HOLD.
- **HOLD:**
  - dump_valid stays high; dump_data and dump_idx are stable.
  - When dump_ready is high: dump_valid <= 0. If idx == 31, go to IDLE and clear dump_busy; otherwise idx <= idx + 1 and go to LOAD.
- **Write blocking:** in LOAD and HOLD, core_stall = 1, both readies are 0, rf_we = 0, and rf_a1 = idx.
- **dump_start ignored** whenever the FSM is not in IDLE.
- **Reset mid-dump:** abort the dump, return to IDLE, clear dump_valid and dump_busy. No further beats are emitted.

## Timing
- Write path is combinational: rf_we is asserted in the handshake cycle, and the register file commits at that cycle's rising edge.
- Dump latency: dump_start in cycle 0 → LOAD in cycle 1 → dump_valid high in cycle 2.
- A write that completes in cycle 0 is visible in the dump, because it commits at the end of cycle 0 and LOAD reads in cycle 1.
- Beat throughput with dump_ready held high: one beat every 2 cycles (LOAD, HOLD). A full dump takes 64 cycles from LOAD of x0 to the HOLD exit of x31.
- dump_busy rises in cycle 1 and falls on the edge that leaves HOLD with idx = 31.
- dump_idx wraps only via completion; there is no rollover past 31.

## Test plan
- **Reset values:**
  - Stimulus: hold rst low for 3 cycles while both requesters are valid.
  - Required: readies = 0, rf_we = 0, dump_valid = 0, dump_busy = 0.
  - Stimulus: release rst with both still valid.
  - Required: core granted first.
- **Round-robin:**
  - Stimulus: core and host continuously valid, core_waddr = 5, host_waddr = 6.
  - Required: grants alternate core, host, core, host; rf_a3 sequence 5, 6, 5, 6; rf_we = 1 each cycle.
- **x0 suppression:**
  - Stimulus: host writes 32'hDEAD_BEEF to x0.
  - Required: host_wready = 1, rf_we = 0, and a following dump reports x0 = 0.
- **Full dump:**
  - Stimulus: preload x8 = 32'h11 and x31 = 32'hA5A5_A5A5, then pulse dump_start with dump_ready = 1.
  - Required: 32 beats with idx 0..31 carrying the matching data; first dump_valid 2 cycles after the pulse; dump_busy low after the idx 31 beat.
- **Backpressure and blocking:**
  - Stimulus: during a dump, hold dump_ready = 0 for 5 cycles at idx 3 while core_wvalid = 1.
  - Required: dump_valid, dump_idx = 3 and dump_data stay stable; core_wready = 0; core_stall = 1.
  - Stimulus: after dump completion.
  - Required: the core write is accepted.
- **Abort and restart:**
  - Stimulus: assert rst at beat idx 10.
  - Required: next cycle is IDLE with dump_valid = 0.
  - Stimulus: a new dump_start.
  - Required: dump restarts at idx 0.
  - Stimulus: dump_start pulsed mid-dump.
  - Required: ignored.
